// File: rtl/complex_addsub_accumulator.sv
// complex_addsub_accumulator
// Pipelined complex add/subtract with valid tracking, running accumulation,
// a gated hold register and a sticky part-overflow flag.
// Build option: define COMPLEX_ADDSUB_SATURATE_EN to saturate out-of-range
// parts instead of wrapping them modulo 2^PART_W.
module complex_addsub_accumulator #(
    parameter int PART_W  = 32,
    parameter int LATENCY = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_ce,
    input  logic                i_start,
    input  logic                i_in_valid,
    output logic                o_in_ready,
    input  logic                i_op,
    input  logic                i_acc_mode,
    input  logic                i_acc_clear,
    input  logic                i_capture,
    input  logic [2*PART_W-1:0] i_a,
    input  logic [2*PART_W-1:0] i_b,
    output logic [2*PART_W-1:0] o_result,
    output logic                o_result_valid,
    output logic [2*PART_W-1:0] o_held_output,
    output logic [2*PART_W-1:0] o_acc_value,
    output logic                o_overflow
);

    localparam int CW   = 2 * PART_W;
    localparam int LAST = LATENCY - 1;

    // One part: compute at PART_W+1 bits, return {overflow, reduced value}.
    function automatic logic [PART_W:0] part_addsub(
        input logic [PART_W-1:0] a,
        input logic [PART_W-1:0] b,
        input logic              sub
    );
        logic [PART_W:0]   ext;
        logic              ovf;
        logic [PART_W-1:0] val;
        if (sub) begin
            ext = {a[PART_W-1], a} - {b[PART_W-1], b};
        end else begin
            ext = {a[PART_W-1], a} + {b[PART_W-1], b};
        end
        // The two top bits disagree exactly when the true value leaves the PART_W range.
        ovf = ext[PART_W] ^ ext[PART_W-1];
`ifdef COMPLEX_ADDSUB_SATURATE_EN
        if (ovf) begin
            val = ext[PART_W] ? {1'b1, {(PART_W-1){1'b0}}} : {1'b0, {(PART_W-1){1'b1}}};
        end else begin
            val = ext[PART_W-1:0];
        end
`else
        val = ext[PART_W-1:0];
`endif
        return {ovf, val};
    endfunction

    logic [LATENCY-1:0] r_vld;
    logic [LATENCY-1:0] r_accb;
    logic [LATENCY-1:0] r_ovf;
    logic [CW-1:0]      r_data [LATENCY];
    logic [CW-1:0]      r_acc;
    logic [CW-1:0]      r_hold;
    logic               r_overflow;

    logic [CW-1:0]      w_bsel;
    logic [PART_W:0]    w_re;
    logic [PART_W:0]    w_im;
    logic [CW-1:0]      w_sum;
    logic               w_ovf;
    logic               w_busy;
    logic               w_accept;
    logic               w_out_acc;

    // Accumulator feedback replaces B; the accumulator is stable at accept
    // time because accepts are blocked while an acc-mode op is in flight.
    assign w_bsel   = i_acc_mode ? r_acc : i_b;
    assign w_re     = part_addsub(i_a[CW-1:PART_W], w_bsel[CW-1:PART_W], i_op);
    assign w_im     = part_addsub(i_a[PART_W-1:0], w_bsel[PART_W-1:0], i_op);
    assign w_sum    = {w_re[PART_W-1:0], w_im[PART_W-1:0]};
    assign w_ovf    = w_re[PART_W] | w_im[PART_W];

    // Any acc-mode op in any stage, including the output stage, blocks new input.
    assign w_busy     = |(r_vld & r_accb);
    assign o_in_ready = ~w_busy;
    assign w_accept   = i_in_valid & o_in_ready & i_ce;
    assign w_out_acc  = r_vld[LAST] & r_accb[LAST];

    // First pipeline stage: capture the computed result on accept.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld[0]  <= 1'b0;
            r_accb[0] <= 1'b0;
            r_ovf[0]  <= 1'b0;
            r_data[0] <= '0;
        end else if (i_ce) begin
            r_vld[0] <= w_accept;
            if (w_accept) begin
                r_accb[0] <= i_acc_mode;
                r_ovf[0]  <= w_ovf;
                r_data[0] <= w_sum;
            end
        end
    end

    for (genvar g = 1; g < LATENCY; g++) begin : g_stage
        // Later stages: payload moves only with a valid, so the last stage holds its value.
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_vld[g]  <= 1'b0;
                r_accb[g] <= 1'b0;
                r_ovf[g]  <= 1'b0;
                r_data[g] <= '0;
            end else if (i_ce) begin
                r_vld[g] <= r_vld[g-1];
                if (r_vld[g-1]) begin
                    r_accb[g] <= r_accb[g-1];
                    r_ovf[g]  <= r_ovf[g-1];
                    r_data[g] <= r_data[g-1];
                end
            end
        end
    end

    // Accumulator: clear wins over write-back of an emerging acc-mode result.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (i_ce) begin
            if (i_acc_clear) begin
                r_acc <= '0;
            end else if (w_out_acc) begin
                r_acc <= r_data[LAST];
            end
        end
    end

    // Sticky overflow, set as a flagged result emerges; cleared with the accumulator.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_overflow <= 1'b0;
        end else if (i_ce) begin
            if (i_acc_clear) begin
                r_overflow <= 1'b0;
            end else if (r_vld[LAST] && r_ovf[LAST]) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Hold register: capture beats session-end clearing.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hold <= '0;
        end else if (i_ce) begin
            if (r_vld[LAST] && i_capture) begin
                r_hold <= r_data[LAST];
            end else if (!i_start) begin
                r_hold <= '0;
            end
        end
    end

    assign o_result       = r_data[LAST];
    assign o_result_valid = r_vld[LAST];
    assign o_acc_value    = r_acc;
    assign o_overflow     = r_overflow;
    assign o_held_output  = (i_capture && r_vld[LAST]) ? r_data[LAST] : r_hold;

endmodule

// File: tb/tb_complex_addsub_accumulator.sv
// Directed self-checking bench for complex_addsub_accumulator (PART_W=32, LATENCY=2).
module tb_complex_addsub_accumulator;

    logic        clk = 1'b0;
    logic        rst, ce, start, in_valid, op, acc_mode, acc_clear, capture;
    logic        in_ready, result_valid, overflow;
    logic [63:0] a, b, result, held_output, acc_value;

    int total = 0;
    int bad   = 0;

    complex_addsub_accumulator #(.PART_W(32), .LATENCY(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_ce(ce), .i_start(start),
        .i_in_valid(in_valid), .o_in_ready(in_ready), .i_op(op),
        .i_acc_mode(acc_mode), .i_acc_clear(acc_clear), .i_capture(capture),
        .i_a(a), .i_b(b), .o_result(result), .o_result_valid(result_valid),
        .o_held_output(held_output), .o_acc_value(acc_value), .o_overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] cpx(input logic [31:0] re, input logic [31:0] im);
        return {re, im};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [63:0] va, input logic [63:0] vb, input logic vop, input logic vam);
        a = va; b = vb; op = vop; acc_mode = vam; in_valid = 1'b1;
        tick();
        in_valid = 1'b0; acc_mode = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!result_valid && n < 20) begin
            tick();
            n++;
        end
        if (!result_valid) check_val("timeout", 64'd0, 64'd1);
    endtask

    int n;
    int vcount;

    initial begin
        rst = 1'b1; ce = 1'b1; start = 1'b1; in_valid = 1'b0; op = 1'b0;
        acc_mode = 1'b0; acc_clear = 1'b0; capture = 1'b0; a = 64'd0; b = 64'd0;
        tick(); tick();
        rst = 1'b0;
        check_val("rst_valid", {63'd0, result_valid}, 64'd0);
        check_val("rst_result", result, 64'd0);
        check_val("rst_acc", acc_value, 64'd0);
        check_val("rst_ovf", {63'd0, overflow}, 64'd0);
        check_val("rst_ready", {63'd0, in_ready}, 64'd1);

        // {5,-3} + {2,7}
        send(cpx(32'd5, 32'hFFFF_FFFD), cpx(32'd2, 32'd7), 1'b0, 1'b0);
        check_val("add_early", {63'd0, result_valid}, 64'd0);
        wait_valid(n);
        check_val("add_lat", 64'(n), 64'd1);
        check_val("add_res", result, cpx(32'd7, 32'd4));
        tick();
        check_val("add_pulse", {63'd0, result_valid}, 64'd0);
        check_val("add_holdres", result, cpx(32'd7, 32'd4));
        check_val("add_ovf", {63'd0, overflow}, 64'd0);

        // {5,-3} - {2,7}
        send(cpx(32'd5, 32'hFFFF_FFFD), cpx(32'd2, 32'd7), 1'b1, 1'b0);
        wait_valid(n);
        check_val("sub_res", result, cpx(32'd3, 32'hFFFF_FFF6));
        tick();

        // Four back-to-back pairs: A={i+1,i+1}, B={1,0}
        vcount = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc < 4) begin
                a = cpx(32'(cyc + 1), 32'(cyc + 1)); b = cpx(32'd1, 32'd0);
                op = 1'b0; in_valid = 1'b1;
                check_val("b2b_ready", {63'd0, in_ready}, 64'd1);
            end else begin
                in_valid = 1'b0;
            end
            tick();
            if (result_valid) vcount++;
            if (cyc >= 1 && cyc <= 4) begin
                check_val("b2b_valid", {63'd0, result_valid}, 64'd1);
                check_val("b2b_res", result, cpx(32'(cyc + 1), 32'(cyc)));
            end
        end
        check_val("b2b_count", 64'(vcount), 64'd4);

        // Accumulate {1,1} three times; B is ignored
        acc_clear = 1'b1; tick(); acc_clear = 1'b0;
        check_val("accclr", acc_value, 64'd0);
        for (int k = 1; k <= 3; k++) begin
            check_val("acc_ready_pre", {63'd0, in_ready}, 64'd1);
            send(cpx(32'd1, 32'd1), cpx(32'd100, 32'd100), 1'b0, 1'b1);
            check_val("acc_busy", {63'd0, in_ready}, 64'd0);
            wait_valid(n);
            check_val("acc_busy_out", {63'd0, in_ready}, 64'd0);
            check_val("acc_res", result, cpx(32'(k), 32'(k)));
            tick();
            check_val("acc_ready_post", {63'd0, in_ready}, 64'd1);
            check_val("acc_val", acc_value, cpx(32'(k), 32'(k)));
        end

        // Capture {9,9}, then hold, then clear with start low
        send(cpx(32'd4, 32'd4), cpx(32'd5, 32'd5), 1'b0, 1'b0);
        wait_valid(n);
        capture = 1'b1; #1;
        check_val("cap_live", held_output, cpx(32'd9, 32'd9));
        tick();
        capture = 1'b0; start = 1'b1; #1;
        check_val("cap_held", held_output, cpx(32'd9, 32'd9));
        tick(); tick();
        check_val("cap_keep", held_output, cpx(32'd9, 32'd9));
        start = 1'b0; #1;
        check_val("cap_noclr_yet", held_output, cpx(32'd9, 32'd9));
        tick();
        check_val("cap_clr", held_output, 64'd0);
        start = 1'b1;

        // Positive overflow on real part
        send(cpx(32'h7FFF_FFFF, 32'd0), cpx(32'd1, 32'd0), 1'b0, 1'b0);
        wait_valid(n);
`ifdef COMPLEX_ADDSUB_SATURATE_EN
        check_val("ovf_pos_res", result, cpx(32'h7FFF_FFFF, 32'd0));
`else
        check_val("ovf_pos_res", result, cpx(32'h8000_0000, 32'd0));
`endif
        tick();
        check_val("ovf_set", {63'd0, overflow}, 64'd1);
        acc_clear = 1'b1; tick(); acc_clear = 1'b0;
        check_val("ovf_clr", {63'd0, overflow}, 64'd0);

        // Negative overflow via subtraction
        send(cpx(32'h8000_0000, 32'd0), cpx(32'd1, 32'd0), 1'b1, 1'b0);
        wait_valid(n);
`ifdef COMPLEX_ADDSUB_SATURATE_EN
        check_val("ovf_neg_res", result, cpx(32'h8000_0000, 32'd0));
`else
        check_val("ovf_neg_res", result, cpx(32'h7FFF_FFFF, 32'd0));
`endif
        tick();
        check_val("ovf_neg_set", {63'd0, overflow}, 64'd1);
        acc_clear = 1'b1; tick(); acc_clear = 1'b0;

        // ce low for 3 cycles mid-pipeline
        send(cpx(32'd10, 32'd20), cpx(32'd1, 32'd2), 1'b0, 1'b0);
        ce = 1'b0;
        for (int s = 0; s < 3; s++) begin
            tick();
            check_val("ce_stall", {63'd0, result_valid}, 64'd0);
        end
        ce = 1'b1;
        wait_valid(n);
        check_val("ce_lat", 64'(n), 64'd1);
        check_val("ce_res", result, cpx(32'd11, 32'd22));
        tick();

        // Reset mid-pipeline discards in-flight work
        send(cpx(32'd2, 32'd2), cpx(32'd0, 32'd0), 1'b0, 1'b1);
        wait_valid(n);
        tick();
        check_val("pre_rst_acc", acc_value, cpx(32'd2, 32'd2));
        send(cpx(32'd3, 32'd3), cpx(32'd3, 32'd3), 1'b0, 1'b0);
        rst = 1'b1; tick(); rst = 1'b0;
        vcount = 0;
        for (int s = 0; s < 5; s++) begin
            if (result_valid) vcount++;
            tick();
        end
        check_val("rst_mid_novalid", 64'(vcount), 64'd0);
        check_val("rst_mid_res", result, 64'd0);
        check_val("rst_mid_acc", acc_value, 64'd0);
        check_val("rst_mid_held", held_output, 64'd0);
        check_val("rst_mid_ready", {63'd0, in_ready}, 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
